hazard_ctrl: RTL and testbench

- Pipeline sequencer for the 5-stage MIPS core. Generates the stall, flush and freeze controls that drive the PC, IF/ID, ID/EX (ID_Flush_lwstall, ID_Flush_Branch) and EX/MEM pipeline registers.
- Arbitrates between three hazard sources: load-use, taken branch/jump resolved in MEM, and a multi-cycle data-memory wait.
- Also keeps saturating performance counters for stalls and flushes.

---
 rtl/hazard_ctrl_pkg.sv | 12 +
 rtl/hazard_ctrl_if.sv | 42 ++++
 rtl/hazard_ctrl_sat_counter.sv | 21 ++
 rtl/hazard_ctrl.sv | 108 ++++++++++
 tb/tb_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-detection inputs and pipeline-register controls between the core and the sequencer.
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);
    logic             ID_EX_MemRead;
    logic [REG_W-1:0] ID_EX_RegisterRt;
    logic [REG_W-1:0] IF_ID_RegisterRs;
    logic [REG_W-1:0] IF_ID_RegisterRt;
    logic             IF_ID_UsesRt;
    logic             MEM_Branch_taken;
    logic             MEM_Jump;
    logic             dmem_req;
    logic             dmem_ready;

    logic             PC_Write;
    logic             PC_Sel_Target;
    logic             IF_ID_Write;
    logic             IF_Flush;
    logic             ID_Flush_lwstall;
    logic             ID_Flush_Branch;
    logic             EX_Flush;
    logic             Freeze;
    logic             mem_error;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
               IF_ID_UsesRt, MEM_Branch_taken, MEM_Jump, dmem_req, dmem_ready,
        input  PC_Write, PC_Sel_Target, IF_ID_Write, IF_Flush, ID_Flush_lwstall,
               ID_Flush_Branch, EX_Flush, Freeze, mem_error, stall_count, flush_count
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
               IF_ID_UsesRt, MEM_Branch_taken, MEM_Jump, dmem_req, dmem_ready,
        output PC_Write, PC_Sel_Target, IF_ID_Write, IF_Flush, ID_Flush_lwstall,
               ID_Flush_Branch, EX_Flush, Freeze, mem_error, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: holds at all-ones, cleared only by reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline with memory-wait timeout
// and saturating stall/flush performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz
);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mem_error_q, mem_error_d;
    logic              stall_inc, flush_inc;
    logic              lu, ch, mw;

    assign lu = hz.ID_EX_MemRead && (hz.ID_EX_RegisterRt != REG_ZERO) &&
                ((hz.ID_EX_RegisterRt == hz.IF_ID_RegisterRs) ||
                 (hz.IF_ID_UsesRt && (hz.ID_EX_RegisterRt == hz.IF_ID_RegisterRt)));
    assign ch = hz.MEM_Branch_taken || hz.MEM_Jump;
    assign mw = hz.dmem_req && !hz.dmem_ready;

    // Next-state and control decode; reset forces the pass-through defaults.
    always_comb begin
        hz.PC_Write         = 1'b1;
        hz.PC_Sel_Target    = 1'b0;
        hz.IF_ID_Write      = 1'b1;
        hz.IF_Flush         = 1'b0;
        hz.ID_Flush_lwstall = 1'b0;
        hz.ID_Flush_Branch  = 1'b0;
        hz.EX_Flush         = 1'b0;
        hz.Freeze           = 1'b0;
        state_d             = state_q;
        wait_d              = wait_q;
        mem_error_d         = mem_error_q;
        stall_inc           = 1'b0;
        flush_inc           = 1'b0;

        if (!reset) begin
            if ((state_q == MEM_WAIT) && !hz.dmem_ready) begin
                hz.Freeze      = 1'b1;
                hz.PC_Write    = 1'b0;
                hz.IF_ID_Write = 1'b0;
                stall_inc      = 1'b1;
                // Abandon the access after the timeout window; Freeze drops next cycle.
                if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
                    mem_error_d = 1'b1;
                    state_d     = RUN;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end else begin
                state_d = RUN;
                if (mw) begin
                    hz.Freeze      = 1'b1;
                    hz.PC_Write    = 1'b0;
                    hz.IF_ID_Write = 1'b0;
                    state_d        = MEM_WAIT;
                    wait_d         = WAIT_W'(1);
                    stall_inc      = 1'b1;
                end else if (ch) begin
                    hz.PC_Sel_Target   = 1'b1;
                    hz.IF_Flush        = 1'b1;
                    hz.ID_Flush_Branch = 1'b1;
                    hz.EX_Flush        = 1'b1;
                    flush_inc          = 1'b1;
                end else if (lu) begin
                    hz.PC_Write         = 1'b0;
                    hz.IF_ID_Write      = 1'b0;
                    hz.ID_Flush_lwstall = 1'b1;
                    stall_inc           = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            wait_q      <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign hz.mem_error = mem_error_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (hz.stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (hz.flush_count)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a rule-level behavioural model.
module tb_hazard_ctrl;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned MEM_TIMEOUT = 15;
    localparam int          CNT_MAX     = (1 << CNT_W) - 1;

    // Control vector bit order: PC_Write, PC_Sel_Target, IF_ID_Write, IF_Flush,
    // ID_Flush_lwstall, ID_Flush_Branch, EX_Flush, Freeze.
    localparam logic [7:0] C_IDLE   = 8'b1010_0000;
    localparam logic [7:0] C_FREEZE = 8'b0000_0001;
    localparam logic [7:0] C_FLUSH  = 8'b1111_0110;
    localparam logic [7:0] C_LU     = 8'b0000_1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus();

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: waiting on memory, cycles spent waiting, sticky error, event totals.
    bit m_wait;
    int m_wcnt;
    bit m_err;
    int m_sc;
    int m_fc;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit load_use();
        logic [4:0] srcs[$];
        bit hit = 1'b0;
        srcs.push_back(bus.IF_ID_RegisterRs);
        if (bus.IF_ID_UsesRt) srcs.push_back(bus.IF_ID_RegisterRt);
        foreach (srcs[k]) if (srcs[k] == bus.ID_EX_RegisterRt) hit = 1'b1;
        return bus.ID_EX_MemRead && (bus.ID_EX_RegisterRt != 5'd0) && hit;
    endfunction

    function automatic logic [7:0] expected_ctrl();
        if (reset) return C_IDLE;
        if (!bus.dmem_ready && (m_wait || bus.dmem_req)) return C_FREEZE;
        if (bus.MEM_Branch_taken || bus.MEM_Jump) return C_FLUSH;
        if (load_use()) return C_LU;
        return C_IDLE;
    endfunction

    function automatic logic [7:0] dut_ctrl();
        return {bus.PC_Write, bus.PC_Sel_Target, bus.IF_ID_Write, bus.IF_Flush,
                bus.ID_Flush_lwstall, bus.ID_Flush_Branch, bus.EX_Flush, bus.Freeze};
    endfunction

    // One clock: compare mid-cycle, then advance the model at the edge.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        e = expected_ctrl();
        check("ctrl", 16'(dut_ctrl()), 16'(e));
        check("mem_error", 16'(bus.mem_error), 16'(m_err));
        check("stall_count", 16'(bus.stall_count), 16'(m_sc));
        check("flush_count", 16'(bus.flush_count), 16'(m_fc));
        @(posedge clk);
        if (reset) begin
            m_wait = 1'b0; m_wcnt = 0; m_err = 1'b0; m_sc = 0; m_fc = 0;
        end else begin
            if (e == C_FREEZE || e == C_LU) m_sc = (m_sc < CNT_MAX) ? m_sc + 1 : CNT_MAX;
            if (e == C_FLUSH)               m_fc = (m_fc < CNT_MAX) ? m_fc + 1 : CNT_MAX;
            if (m_wait) begin
                if (bus.dmem_ready) m_wait = 1'b0;
                else if (m_wcnt == MEM_TIMEOUT) begin m_err = 1'b1; m_wait = 1'b0; end
                else m_wcnt++;
            end else if (bus.dmem_req && !bus.dmem_ready) begin
                m_wait = 1'b1;
                m_wcnt = 1;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        bus.ID_EX_MemRead    = 1'b0;
        bus.ID_EX_RegisterRt = 5'd0;
        bus.IF_ID_RegisterRs = 5'd0;
        bus.IF_ID_RegisterRt = 5'd0;
        bus.IF_ID_UsesRt     = 1'b0;
        bus.MEM_Branch_taken = 1'b0;
        bus.MEM_Jump         = 1'b0;
        bus.dmem_req         = 1'b0;
        bus.dmem_ready       = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        m_wait = 1'b0; m_wcnt = 0; m_err = 1'b0; m_sc = 0; m_fc = 0;
        reset = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        tick();
        reset = 1'b0;
        #1;
        check("rst_pc_write", 16'(bus.PC_Write), 16'd1);
        check("rst_freeze", 16'(bus.Freeze), 16'd0);
        check("rst_stall_count", 16'(bus.stall_count), 16'd0);

        // Load-use on Rs: one bubble, one stall counted.
        bus.ID_EX_MemRead = 1'b1; bus.ID_EX_RegisterRt = 5'd8; bus.IF_ID_RegisterRs = 5'd8;
        #1;
        check("lu_pc_write", 16'(bus.PC_Write), 16'd0);
        check("lu_bubble", 16'(bus.ID_Flush_lwstall), 16'd1);
        tick();
        bus.ID_EX_MemRead = 1'b0;
        #1;
        check("lu_stall_count", 16'(bus.stall_count), 16'd1);
        check("lu_released", 16'(bus.PC_Write), 16'd1);
        tick();

        // $0 never stalls.
        bus.ID_EX_MemRead = 1'b1; bus.ID_EX_RegisterRt = 5'd0; bus.IF_ID_RegisterRs = 5'd0;
        #1;
        check("r0_no_stall", 16'(bus.ID_Flush_lwstall), 16'd0);
        tick();

        // Rt match counts only when the ID instruction reads Rt.
        bus.ID_EX_RegisterRt = 5'd8; bus.IF_ID_RegisterRs = 5'd3; bus.IF_ID_RegisterRt = 5'd8;
        #1;
        check("rt_unused", 16'(bus.ID_Flush_lwstall), 16'd0);
        tick();
        bus.IF_ID_UsesRt = 1'b1;
        #1;
        check("rt_used", 16'(bus.ID_Flush_lwstall), 16'd1);
        tick();

        // Taken branch outranks load-use.
        bus.MEM_Branch_taken = 1'b1;
        #1;
        check("br_ctrl", 16'(dut_ctrl()), 16'(C_FLUSH));
        tick();
        clear_inputs();
        #1;
        check("br_flush_count", 16'(bus.flush_count), 16'd1);
        tick();

        // Memory wait: 4 frozen cycles, released on the ready cycle.
        do_reset();
        bus.dmem_req = 1'b1;
        repeat (4) begin
            #1;
            check("mw_freeze", 16'(bus.Freeze), 16'd1);
            tick();
        end
        bus.dmem_ready = 1'b1;
        #1;
        check("mw_release", 16'(bus.Freeze), 16'd0);
        tick();
        clear_inputs();
        #1;
        check("mw_stall_count", 16'(bus.stall_count), 16'd4);
        check("mw_no_error", 16'(bus.mem_error), 16'd0);

        // Timeout: 16 frozen cycles, then sticky error; counter saturates at 15.
        bus.dmem_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("to_freeze", 16'(bus.Freeze), 16'd1);
            tick();
        end
        bus.dmem_req = 1'b0;
        #1;
        check("to_released", 16'(bus.Freeze), 16'd0);
        check("to_error", 16'(bus.mem_error), 16'd1);
        check("to_sat_count", 16'(bus.stall_count), 16'd15);
        tick();
        #1;
        check("to_error_sticky", 16'(bus.mem_error), 16'd1);

        // Reset in the middle of a wait.
        bus.dmem_req = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("rmw_forced", 16'(bus.Freeze), 16'd0);
        tick();
        reset = 1'b0;
        bus.dmem_req = 1'b0;
        #1;
        check("rmw_freeze", 16'(bus.Freeze), 16'd0);
        check("rmw_stall", 16'(bus.stall_count), 16'd0);
        check("rmw_error", 16'(bus.mem_error), 16'd0);
        tick();

        // 20 back-to-back load-use stalls saturate the 4-bit counter.
        bus.ID_EX_MemRead = 1'b1; bus.ID_EX_RegisterRt = 5'd5; bus.IF_ID_RegisterRs = 5'd5;
        repeat (20) tick();
        clear_inputs();
        #1;
        check("sat_stall_count", 16'(bus.stall_count), 16'd15);
        tick();

        // Randomized traffic with small register ranges to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            reset                = ($urandom_range(0, 99) < 2);
            bus.ID_EX_MemRead    = 1'($urandom_range(0, 1));
            bus.ID_EX_RegisterRt = 5'($urandom_range(0, 3));
            bus.IF_ID_RegisterRs = 5'($urandom_range(0, 3));
            bus.IF_ID_RegisterRt = 5'($urandom_range(0, 3));
            bus.IF_ID_UsesRt     = 1'($urandom_range(0, 1));
            bus.MEM_Branch_taken = ($urandom_range(0, 9) == 0);
            bus.MEM_Jump         = ($urandom_range(0, 9) == 0);
            bus.dmem_req         = ($urandom_range(0, 9) < 3);
            bus.dmem_ready       = ($urandom_range(0, 9) < 3);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
